// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side signal bundle for the branch predict unit.
// The pipeline owns the master side; the predictor is the slave.
interface branch_predict_unit_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic [XLEN-1:0]   f_pc;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              ex_valid;
  logic              ex_branch;
  logic [2:0]        ex_funct3;
  logic              zf;
  logic              vf;
  logic              sf;
  logic              cf;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_target;
  logic              ex_pred_taken;
  logic [XLEN-1:0]   ex_pred_target;
  logic              ex_taken;
  logic              ex_illegal;
  logic              flush;
  logic [XLEN-1:0]   redirect_pc;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output f_pc, ex_valid, ex_branch, ex_funct3, zf, vf, sf, cf,
           ex_pc, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, ex_taken, ex_illegal,
           flush, redirect_pc, perf_branches, perf_mispred
  );

  modport slave (
    input  f_pc, ex_valid, ex_branch, ex_funct3, zf, vf, sf, cf,
           ex_pc, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, ex_taken, ex_illegal,
           flush, redirect_pc, perf_branches, perf_mispred
  );
endinterface

// File: rtl/branch_predict_unit.sv
// RV32 branch resolver plus BHT/BTB fetch predictor with registered flush/redirect
// and saturating branch/mispredict performance counters.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int IDX_LSB     = 2,
  parameter int PERF_W      = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bpu
);
  localparam int IDXW = $clog2(BHT_ENTRIES);
  localparam int TAGW = XLEN - IDX_LSB - IDXW;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] ctr_q       [BHT_ENTRIES];
  logic                btb_valid_q [BHT_ENTRIES];
  logic [TAGW-1:0]     btb_tag_q   [BHT_ENTRIES];
  logic [XLEN-1:0]     btb_tgt_q   [BHT_ENTRIES];

  logic              flush_q;
  logic [XLEN-1:0]   redirect_q, redirect_d;
  logic [PERF_W-1:0] perf_br_q, perf_br_d;
  logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

  logic [IDXW-1:0]     f_idx, ex_idx;
  logic [TAGW-1:0]     f_tag, ex_tag;
  logic                hit;
  logic                res, legal, cond, upd, mispred;
  logic [CTR_BITS-1:0] ctr_d;

  assign f_idx  = bpu.f_pc[IDX_LSB +: IDXW];
  assign f_tag  = bpu.f_pc[XLEN-1 : IDX_LSB+IDXW];
  assign ex_idx = bpu.ex_pc[IDX_LSB +: IDXW];
  assign ex_tag = bpu.ex_pc[XLEN-1 : IDX_LSB+IDXW];

  // No bypass: a same-cycle update to f_idx is seen only from the next cycle.
  assign hit             = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
  assign bpu.pred_taken  = hit & ctr_q[f_idx][CTR_BITS-1];
  assign bpu.pred_target = hit ? btb_tgt_q[f_idx] : '0;

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (bpu.ex_funct3)
      3'b000:  cond = bpu.zf;
      3'b001:  cond = ~bpu.zf;
      3'b100:  cond = bpu.sf ^ bpu.vf;
      3'b101:  cond = ~(bpu.sf ^ bpu.vf);
      3'b110:  cond = ~bpu.cf;
      3'b111:  cond = bpu.cf;
      default: legal = 1'b0;
    endcase
  end

  assign res            = bpu.ex_valid & bpu.ex_branch;
  assign upd            = res & legal;
  assign bpu.ex_taken   = upd & cond;
  assign bpu.ex_illegal = res & ~legal;
  assign mispred = upd & ((bpu.ex_taken != bpu.ex_pred_taken) |
                          (bpu.ex_taken & bpu.ex_pred_taken &
                           (bpu.ex_pred_target != bpu.ex_target)));

  always_comb begin
    ctr_d = ctr_q[ex_idx];
    if (bpu.ex_taken) begin
      if (ctr_q[ex_idx] != '1) ctr_d = ctr_q[ex_idx] + CTR_BITS'(1);
    end else begin
      if (ctr_q[ex_idx] != '0) ctr_d = ctr_q[ex_idx] - CTR_BITS'(1);
    end
  end

  assign redirect_d = bpu.ex_taken ? bpu.ex_target : bpu.ex_pc + XLEN'(4);
  assign perf_br_d  = (upd && perf_br_q != '1) ? perf_br_q + PERF_W'(1) : perf_br_q;
  assign perf_mp_d  = (mispred && perf_mp_q != '1) ? perf_mp_q + PERF_W'(1) : perf_mp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i]       <= CTR_INIT;
        btb_valid_q[i] <= 1'b0;
      end
      flush_q    <= 1'b0;
      redirect_q <= '0;
      perf_br_q  <= '0;
      perf_mp_q  <= '0;
    end else begin
      flush_q   <= mispred;
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
      if (mispred) redirect_q <= redirect_d;
      if (upd) begin
        ctr_q[ex_idx] <= ctr_d;
        if (bpu.ex_taken) btb_valid_q[ex_idx] <= 1'b1;
      end
    end
  end

  // Tag/target payload needs no reset; btb_valid qualifies it.
  always_ff @(posedge clk) begin
    if (rst_n && upd && bpu.ex_taken) begin
      btb_tag_q[ex_idx] <= ex_tag;
      btb_tgt_q[ex_idx] <= bpu.ex_target;
    end
  end

  assign bpu.flush         = flush_q;
  assign bpu.redirect_pc   = redirect_q;
  assign bpu.perf_branches = perf_br_q;
  assign bpu.perf_mispred  = perf_mp_q;
endmodule
